spi_flash_responder: RTL and testbench
======================================

Name: spi_flash_responder

Overview:
- Synthesizable SPI mode-0 responder that emulates a serial NOR flash. It is the far end of our SPI flash read controller, and is used for on-board loopback and as the DUT-side model in controller benches.
- Oversamples spi_sclk, spi_cs and spi_mosi on the system clock, then decodes the opcode.
- Serves READ, RDID, RDSR, WREN, WRDI and PAGE PROGRAM against an external byte-wide memory port.

Parameters:
- ADDR_W, 24, flash address width in bits; addresses wrap at 2^ADDR_W.
- JEDEC_ID, 24'hEF4018, 3-byte identification value returned by RDID, MSB byte first.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- spi_sclk  in  1  SPI clock from the initiator; idles low (mode 0)
- spi_cs  in  1  chip select, active-low
- spi_mosi  in  1  initiator-to-responder data
- spi_miso  out  1  responder-to-initiator data
- mem_rd  out  1  one-cycle read strobe
- mem_addr  out  ADDR_W  memory byte address
- mem_rddata  in  8  read data; valid exactly 1 clk after mem_rd
- mem_wr  out  1  one-cycle write strobe
- mem_wrdata  out  8  write data, valid with mem_wr
- cmd_done  out  1  one-cycle pulse on every spi_cs rising edge that ends a transaction
- busy  out  1  high while spi_cs is low (synchronized)

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: spi_miso=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wrdata=0, cmd_done=0, busy=0, WEL=0, FSM=IDLE.
- Input timing: 2-flop synchronizers on sclk, cs and mosi, followed by edge detect.
  - Required SCLK timing: high and low phases each ≥4 clk.
  - Required CS timing: setup and hold ≥4 clk around SCLK edges.
- Data sampling and driving:
  - mosi is sampled on each detected sclk rise.
  - On each detected sclk fall, spi_miso <= tx_sr[7] and tx_sr shifts left.
  - spi_miso is forced to 0 whenever cs is high.
- Bit handling: 3-bit bit counter; bits are MSB first; a byte completes on the 8th rise.
- FSM states: IDLE, CMD, ADDR, RD_DATA, WR_DATA, ID, STATUS, IGNORE.
  - IDLE -> CMD on cs fall; the bit counter and the address byte counter clear.
  - CMD, on byte complete, decodes the opcode:
    - 0x03 -> ADDR (read).
    - 0x02 -> ADDR (program) if WEL=1, else IGNORE.
    - 0x9F -> ID; tx_sr loads JEDEC_ID[23:16].
    - 0x05 -> STATUS; tx_sr loads {6'b0, WEL, 1'b0} (WIP is always 0).
    - 0x06 -> arms WEL set; takes effect at cs rise.
    - 0x04 -> arms WEL clear; takes effect at cs rise.
    - Any other opcode -> IGNORE.
  - ADDR: shifts in ADDR_W bits, MSB byte first.
    - READ: on the last address bit, issue mem_rd with mem_addr=address. tx_sr loads mem_rddata 1 clk later, before the next sclk fall. -> RD_DATA.
    - PP: -> WR_DATA.
  - RD_DATA, on each byte complete:
    - mem_addr <= mem_addr+1, wrapping from 2^ADDR_W-1 to 0.
    - Issue mem_rd; tx_sr reloads with the next byte.
    - Continues indefinitely until cs rises.
  - WR_DATA, on each byte complete:
    - mem_wr=1 with mem_wrdata=received byte, at the current mem_addr.
    - Then mem_addr[7:0] increments, wrapping within the 256-byte page; the upper bits are unchanged.
  - ID: sends the 3 ID bytes, then 0x00 repeatedly.
  - STATUS: repeats the status byte while cs is low.
  - IGNORE: spi_miso=0; ignores sclk until cs rises.
- cs rise, from any state:
  - Aborts immediately; a partial byte is discarded and generates no mem_wr.
  - FSM -> IDLE; cmd_done pulses for 1 clk.
  - WEL update at cs rise: set or cleared if a full WREN/WRDI opcode was received; cleared after any PP that completed its address phase.
- Reset mid-transaction: immediate return to reset values; no strobes are emitted.

Decomposition:
- Package spi_flash_pkg: opcode constants (OP_READ, OP_PP, OP_RDID, OP_RDSR, OP_WREN, OP_WRDI), FSM state encoding, status-bit indices.
- Sub-module spi_in_sync: 3-input synchronizer with sclk rise/fall and cs rise/fall strobes.

Test Plan:
- RDID: cs low, send 0x9F, clock 32 bits -> miso bytes EF, 40, 18, 00; cmd_done pulses once at cs rise.
- READ: mem returns addr[7:0]; send 03 00 00 10 and clock 3 bytes -> miso bytes 10, 11, 12; mem_rd pulses at addresses 0x10, 0x11, 0x12.
- READ wrap: send 03 FF FF FF and clock 2 bytes -> miso bytes FF, 00; second mem_rd has mem_addr=0x000000.
- Page program:
  - Send 06, raise cs, then 05 -> status 0x02.
  - Send 02 00 01 FE with data A1 A2 A3 -> mem_wr at 0x0001FE, 0x0001FF, 0x000100 with data A1, A2, A3.
  - Then send 05 -> status 0x00.
- Program without WREN: send 02 00 00 00 AA -> no mem_wr; miso stays 0.
- Abort: raise cs after 12 address bits of a READ, then send 9F -> no mem_rd; RDID returns EF correctly. Assert rst_n low mid-PP -> all outputs at reset values and WEL=0.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared constants for the SPI NOR flash responder:
// opcodes, FSM state encodings and status register bit positions.
package spi_flash_pkg;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDI = 8'h04;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CMD     = 3'd1;
    localparam logic [2:0] ST_ADDR    = 3'd2;
    localparam logic [2:0] ST_RD_DATA = 3'd3;
    localparam logic [2:0] ST_WR_DATA = 3'd4;
    localparam logic [2:0] ST_ID      = 3'd5;
    localparam logic [2:0] ST_STATUS  = 3'd6;
    localparam logic [2:0] ST_IGNORE  = 3'd7;

    localparam int SR_WIP = 0;
    localparam int SR_WEL = 1;

    // WIP is always 0: programming completes instantly
    function automatic logic [7:0] status_byte(input logic wel);
        logic [7:0] b;
        b         = 8'h00;
        b[SR_WIP] = 1'b0;
        b[SR_WEL] = wel;
        return b;
    endfunction

endpackage

// File: rtl/spi_flash_responder_sync.sv
// spi_in_sync: 2-flop synchronizers for sclk/cs/mosi plus edge strobes.
// Ports: clk, rst_n, sclk/cs/mosi in; *_rise/*_fall strobes, cs_lvl, mosi_lvl out.
module spi_in_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic cs,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_rise,
    output logic cs_fall,
    output logic cs_lvl,
    output logic mosi_lvl
);

    logic [2:0] sclk_q;
    logic [2:0] cs_q;
    logic [1:0] mosi_q;

    // cs resets to the deasserted level so reset never fakes a cs edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= 3'b000;
            cs_q   <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            cs_q   <= {cs_q[1:0], cs};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    // mosi_lvl shares sclk_q[1]'s latency so it is aligned with sclk_rise
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_rise   = cs_q[1] & ~cs_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign cs_lvl    = cs_q[1];
    assign mosi_lvl  = mosi_q[1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial NOR flash responder (READ, PP, RDID, RDSR, WREN, WRDI).
// Ports: clk, rst_n; spi_sclk/cs/mosi in, spi_miso out; byte-wide memory
// port mem_rd/mem_addr/mem_rddata/mem_wr/mem_wrdata; cmd_done, busy status.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int          ADDR_W   = 24,
    parameter logic [23:0] JEDEC_ID = 24'hEF4018
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rddata,
    output logic              mem_wr,
    output logic [7:0]        mem_wrdata,
    output logic              cmd_done,
    output logic              busy
);

    localparam logic [2:0] ADDR_LAST = 3'(ADDR_W / 8 - 1);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, cs_lvl, mosi_lvl;

    spi_in_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (spi_sclk),
        .cs        (spi_cs),
        .mosi      (spi_mosi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_rise   (cs_rise),
        .cs_fall   (cs_fall),
        .cs_lvl    (cs_lvl),
        .mosi_lvl  (mosi_lvl)
    );

    logic [2:0]        state;
    logic [2:0]        bit_cnt;
    logic [2:0]        addr_byte;
    logic [6:0]        rx_sr;
    logic [ADDR_W-2:0] addr_sr;
    logic [7:0]        tx_sr;
    logic              miso_q;
    logic              is_read;
    logic              wel;
    logic              wren_arm;
    logic              wrdi_arm;
    logic              pp_armed;
    logic [1:0]        id_idx;
    logic              rd_pend;

    logic              byte_done;
    logic [7:0]        rx_byte;
    logic [ADDR_W-1:0] addr_next;

    assign byte_done = sclk_rise & (bit_cnt == 3'd7);
    assign rx_byte   = {rx_sr, mosi_lvl};
    assign addr_next = {addr_sr, mosi_lvl};

    assign spi_miso = miso_q & ~cs_lvl;
    assign busy     = ~cs_lvl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            addr_byte  <= 3'd0;
            rx_sr      <= 7'd0;
            addr_sr    <= '0;
            tx_sr      <= 8'h00;
            miso_q     <= 1'b0;
            is_read    <= 1'b0;
            wel        <= 1'b0;
            wren_arm   <= 1'b0;
            wrdi_arm   <= 1'b0;
            pp_armed   <= 1'b0;
            id_idx     <= 2'd0;
            rd_pend    <= 1'b0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wrdata <= 8'h00;
            cmd_done   <= 1'b0;
        end else begin
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            cmd_done <= 1'b0;
            rd_pend  <= mem_rd;

            // page-wrapping advance one cycle after each write strobe
            if (mem_wr)
                mem_addr[7:0] <= mem_addr[7:0] + 8'd1;

            if (cs_rise) begin
                state    <= ST_IDLE;
                cmd_done <= 1'b1;
                miso_q   <= 1'b0;
                if (wren_arm)
                    wel <= 1'b1;
                if (wrdi_arm || pp_armed)
                    wel <= 1'b0;
                wren_arm <= 1'b0;
                wrdi_arm <= 1'b0;
                pp_armed <= 1'b0;
            end else if (cs_fall) begin
                state     <= ST_CMD;
                bit_cnt   <= 3'd0;
                addr_byte <= 3'd0;
                tx_sr     <= 8'h00;
                miso_q    <= 1'b0;
                is_read   <= 1'b0;
                id_idx    <= 2'd0;
                wren_arm  <= 1'b0;
                wrdi_arm  <= 1'b0;
                pp_armed  <= 1'b0;
            end else begin
                if (sclk_fall && state != ST_IDLE) begin
                    miso_q <= tx_sr[7];
                    tx_sr  <= {tx_sr[6:0], 1'b0};
                end
                if (sclk_rise && state != ST_IDLE && state != ST_IGNORE) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    rx_sr   <= rx_byte[6:0];
                    case (state)
                        ST_CMD: if (byte_done) begin
                            unique case (1'b1)
                                (rx_byte == OP_READ): begin
                                    is_read <= 1'b1;
                                    state   <= ST_ADDR;
                                end
                                (rx_byte == OP_PP):
                                    state <= wel ? ST_ADDR : ST_IGNORE;
                                (rx_byte == OP_RDID): begin
                                    tx_sr  <= JEDEC_ID[23:16];
                                    id_idx <= 2'd1;
                                    state  <= ST_ID;
                                end
                                (rx_byte == OP_RDSR): begin
                                    tx_sr <= status_byte(wel);
                                    state <= ST_STATUS;
                                end
                                (rx_byte == OP_WREN): begin
                                    wren_arm <= 1'b1;
                                    state    <= ST_IGNORE;
                                end
                                (rx_byte == OP_WRDI): begin
                                    wrdi_arm <= 1'b1;
                                    state    <= ST_IGNORE;
                                end
                                default:
                                    state <= ST_IGNORE;
                            endcase
                        end
                        ST_ADDR: begin
                            addr_sr <= addr_next[ADDR_W-2:0];
                            if (byte_done) begin
                                addr_byte <= addr_byte + 3'd1;
                                if (addr_byte == ADDR_LAST) begin
                                    mem_addr <= addr_next;
                                    if (is_read) begin
                                        mem_rd <= 1'b1;
                                        state  <= ST_RD_DATA;
                                    end else begin
                                        pp_armed <= 1'b1;
                                        state    <= ST_WR_DATA;
                                    end
                                end
                            end
                        end
                        ST_RD_DATA: if (byte_done) begin
                            mem_addr <= mem_addr + ADDR_W'(1);
                            mem_rd   <= 1'b1;
                        end
                        ST_WR_DATA: if (byte_done) begin
                            mem_wr     <= 1'b1;
                            mem_wrdata <= rx_byte;
                        end
                        ST_ID: if (byte_done) begin
                            case (id_idx)
                                2'd1:    tx_sr <= JEDEC_ID[15:8];
                                2'd2:    tx_sr <= JEDEC_ID[7:0];
                                default: tx_sr <= 8'h00;
                            endcase
                            if (id_idx != 2'd3)
                                id_idx <= id_idx + 2'd1;
                        end
                        ST_STATUS: if (byte_done)
                            tx_sr <= status_byte(wel);
                        default: ;
                    endcase
                end
                // read data lands one clk after mem_rd, well before next fall
                if (rd_pend)
                    tx_sr <= mem_rddata;
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench for spi_flash_responder: table of SPI transactions
// plus directed sequences for address order, abort and mid-PP reset.
module tb_spi_flash_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_sclk = 1'b0;
    logic        spi_cs = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        mem_rd;
    logic [23:0] mem_addr;
    logic [7:0]  mem_rddata = 8'h00;
    logic        mem_wr;
    logic [7:0]  mem_wrdata;
    logic        cmd_done;
    logic        busy;

    int checks = 0;
    int failures = 0;

    spi_flash_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_sclk   (spi_sclk),
        .spi_cs     (spi_cs),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rddata (mem_rddata),
        .mem_wr     (mem_wr),
        .mem_wrdata (mem_wrdata),
        .cmd_done   (cmd_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // memory returns the low address byte, one clk after the strobe
    always @(posedge clk)
        if (mem_rd)
            mem_rddata <= mem_addr[7:0];

    logic [23:0] rd_q[$];
    logic [31:0] wr_q[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd)
                rd_q.push_back(mem_addr);
            if (mem_wr)
                wr_q.push_back({mem_addr, mem_wrdata});
            if (cmd_done)
                done_cnt++;
        end
    end

    typedef struct {
        string       name;
        int          n;
        logic [63:0] tx;
        logic [63:0] rx;
        logic [7:0]  chk;
        int          n_rd;
        int          n_wr;
    } vec_t;

    vec_t vt[15];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] tx, input int nb,
                        output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nb; i++) begin
            spi_mosi = tx[7-i];
            wait_clk(5);
            rx[7-i] = spi_miso;
            spi_sclk = 1'b1;
            wait_clk(5);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        wait_clk(5);
    endtask

    task automatic cs_high();
        wait_clk(5);
        spi_cs = 1'b1;
        spi_mosi = 1'b0;
        wait_clk(10);
    endtask

    task automatic run_txn(input logic [63:0] tx, input int n,
                           output logic [63:0] rx);
        logic [7:0] b;
        rx = 64'h0;
        cs_low();
        for (int i = 0; i < n; i++) begin
            xfer(tx[63-8*i -: 8], 8, b);
            rx[63-8*i -: 8] = b;
        end
        cs_high();
    endtask

    task automatic set_vec(input int k, input string nm, input int n,
                           input logic [63:0] tx, input logic [63:0] rx,
                           input logic [7:0] chk, input int nrd,
                           input int nwr);
        vt[k] = '{nm, n, tx, rx, chk, nrd, nwr};
    endtask

    initial begin
        logic [63:0] rx;
        logic [7:0]  b;
        int rb, wb, db;

        set_vec(0,  "rdid",    5, 64'h9F00000000000000,
                64'h00EF401800000000, 8'h1E, 0, 0);
        set_vec(1,  "read",    7, 64'h0300001000000000,
                64'h0000000010111200, 8'h70, 4, 0);
        set_vec(2,  "rd_wrap", 6, 64'h03FFFFFF00000000,
                64'h00000000FF000000, 8'h30, 3, 0);
        set_vec(3,  "wren",    1, 64'h0600000000000000,
                64'h0, 8'h01, 0, 0);
        set_vec(4,  "rdsr_we", 3, 64'h0500000000000000,
                64'h0002020000000000, 8'h07, 0, 0);
        set_vec(5,  "pp",      7, 64'h020001FEA1A2A300,
                64'h0, 8'h7F, 0, 3);
        set_vec(6,  "rdsr_pp", 2, 64'h0500000000000000,
                64'h0, 8'h03, 0, 0);
        set_vec(7,  "pp_nowe", 5, 64'h02000000AA000000,
                64'h0, 8'h1F, 0, 0);
        set_vec(8,  "wren2",   1, 64'h0600000000000000,
                64'h0, 8'h01, 0, 0);
        set_vec(9,  "wrdi",    1, 64'h0400000000000000,
                64'h0, 8'h01, 0, 0);
        set_vec(10, "rdsr_wd", 2, 64'h0500000000000000,
                64'h0, 8'h03, 0, 0);
        set_vec(11, "bad_op",  3, 64'hAB55FF0000000000,
                64'h0, 8'h07, 0, 0);
        set_vec(12, "wren3",   1, 64'h0600000000000000,
                64'h0, 8'h01, 0, 0);
        set_vec(13, "rdsr_a",  2, 64'h0500000000000000,
                64'h0002000000000000, 8'h03, 0, 0);
        set_vec(14, "rdsr_b",  2, 64'h0500000000000000,
                64'h0002000000000000, 8'h03, 0, 0);

        wait_clk(3);
        check("rst_miso", 32'(spi_miso), 0);
        check("rst_rd", 32'(mem_rd), 0);
        check("rst_wr", 32'(mem_wr), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_wdata", 32'(mem_wrdata), 0);
        check("rst_done", 32'(cmd_done), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        wait_clk(5);

        for (int v = 0; v < 15; v++) begin
            rb = rd_q.size();
            wb = wr_q.size();
            db = done_cnt;
            run_txn(vt[v].tx, vt[v].n, rx);
            for (int i = 0; i < vt[v].n; i++)
                if (vt[v].chk[i])
                    check($sformatf("%s_b%0d", vt[v].name, i),
                          32'(rx[63-8*i -: 8]), 32'(vt[v].rx[63-8*i -: 8]));
            check($sformatf("%s_nrd", vt[v].name), rd_q.size() - rb,
                  vt[v].n_rd);
            check($sformatf("%s_nwr", vt[v].name), wr_q.size() - wb,
                  vt[v].n_wr);
            check($sformatf("%s_done", vt[v].name), done_cnt - db, 1);
        end

        // READ address order
        rb = rd_q.size();
        run_txn(64'h0300001000000000, 7, rx);
        check("rd_a0", 32'(rd_q[rb]), 32'h10);
        check("rd_a1", 32'(rd_q[rb+1]), 32'h11);
        check("rd_a2", 32'(rd_q[rb+2]), 32'h12);

        // READ wrap to zero
        rb = rd_q.size();
        run_txn(64'h03FFFFFF00000000, 6, rx);
        check("wrap_a0", 32'(rd_q[rb]), 32'hFFFFFF);
        check("wrap_a1", 32'(rd_q[rb+1]), 32'h000000);

        // page program wraps within the page (WEL still set)
        wb = wr_q.size();
        run_txn(64'h020001FEA1A2A300, 7, rx);
        check("pp_nwr", wr_q.size() - wb, 3);
        check("pp_w0", wr_q[wb], 32'h0001FEA1);
        check("pp_w1", wr_q[wb+1], 32'h0001FFA2);
        check("pp_w2", wr_q[wb+2], 32'h000100A3);

        // abort READ after 12 address bits, then RDID
        rb = rd_q.size();
        db = done_cnt;
        cs_low();
        xfer(8'h03, 8, b);
        xfer(8'h00, 8, b);
        xfer(8'h00, 4, b);
        check("abort_busy", 32'(busy), 1);
        cs_high();
        check("abort_nrd", rd_q.size() - rb, 0);
        check("abort_done", done_cnt - db, 1);
        run_txn(64'h9F00000000000000, 4, rx);
        check("abort_id0", 32'(rx[55:48]), 32'hEF);
        check("abort_id1", 32'(rx[47:40]), 32'h40);

        // reset in the middle of a page program
        run_txn(64'h0600000000000000, 1, rx);
        wb = wr_q.size();
        db = done_cnt;
        cs_low();
        xfer(8'h02, 8, b);
        xfer(8'h00, 8, b);
        xfer(8'h01, 8, b);
        xfer(8'h23, 8, b);
        xfer(8'hA5, 8, b);
        xfer(8'h5A, 4, b);
        check("mid_wdata", 32'(mem_wrdata), 32'hA5);
        check("mid_addr", 32'(mem_addr), 32'h000124);
        rst_n = 1'b0;
        wait_clk(2);
        check("mrst_miso", 32'(spi_miso), 0);
        check("mrst_rd", 32'(mem_rd), 0);
        check("mrst_wr", 32'(mem_wr), 0);
        check("mrst_addr", 32'(mem_addr), 0);
        check("mrst_wdata", 32'(mem_wrdata), 0);
        check("mrst_done", 32'(cmd_done), 0);
        check("mrst_busy", 32'(busy), 0);
        spi_cs = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(10);
        check("mrst_nwr", wr_q.size() - wb, 1);
        check("mrst_ndone", done_cnt - db, 0);
        run_txn(64'h0500000000000000, 2, rx);
        check("mrst_wel", 32'(rx[55:48]), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
